// File: rtl/aes_pkg.sv
// Shared AES front-end definitions: opcodes, payload widths and packer states.
package aes_pkg;

    localparam int KEY_W = 256;
    localparam int BLK_W = 128;

    typedef enum logic [6:0] {
        OP_KEY = 7'd0,
        OP_ENC = 7'd1,
        OP_DEC = 7'd2
    } opcode_e;

    typedef enum logic [1:0] {
        S_HDR,
        S_COLLECT,
        S_ISSUE
    } pkt_state_e;

endpackage

// File: rtl/aes_cmd_packer.sv
// Packs a header word plus 32-bit payload words into one AES core command
// and issues it over a valid/ready handshake.
module aes_cmd_packer
    import aes_pkg::*;
#(
    parameter int WORD_W = 32,
    parameter int KEY_W  = aes_pkg::KEY_W,
    parameter int BLK_W  = aes_pkg::BLK_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_data,
    output logic              core_valid,
    input  logic              core_ready,
    output logic [6:0]        opcode,
    output logic [KEY_W-1:0]  data_in,
    output logic              err,
    output logic              key_loaded,
    output logic              busy
);

    localparam int CNT_W = $clog2(KEY_W / WORD_W) + 1;
    localparam logic [CNT_W-1:0] KEY_LAST = CNT_W'(KEY_W / WORD_W - 1);
    localparam logic [CNT_W-1:0] BLK_LAST = CNT_W'(BLK_W / WORD_W - 1);

    pkt_state_e       state;
    opcode_e          op_q;
    logic [CNT_W-1:0] cnt;
    logic [6:0]       hdr_op;
    logic             hdr_ok;
    logic             word_xfer;
    logic             issue_xfer;
    logic [CNT_W-1:0] last_idx;

    // Handshakes are masked during reset so nothing transfers in that cycle.
    always_comb begin
        hdr_op     = in_data[6:0];
        hdr_ok     = 1'b0;
        if (hdr_op == OP_KEY) begin
            hdr_ok = 1'b1;
        end else if ((hdr_op == OP_ENC || hdr_op == OP_DEC) && key_loaded) begin
            hdr_ok = 1'b1;
        end
        in_ready   = !rst && (state != S_ISSUE);
        core_valid = !rst && (state == S_ISSUE);
        busy       = (state != S_HDR);
        word_xfer  = in_valid && in_ready;
        issue_xfer = core_valid && core_ready;
        last_idx   = (op_q == OP_KEY) ? KEY_LAST : BLK_LAST;
        opcode     = op_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_HDR;
            op_q       <= OP_KEY;
            data_in    <= '0;
            err        <= 1'b0;
            key_loaded <= 1'b0;
            cnt        <= '0;
        end else begin
            err <= 1'b0;
            case (state)
                S_HDR: begin
                    if (word_xfer) begin
                        if (hdr_ok) begin
                            op_q    <= opcode_e'(hdr_op);
                            data_in <= '0;
                            cnt     <= '0;
                            state   <= S_COLLECT;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                S_COLLECT: begin
                    // Payload fills from the top; block commands leave the low half zero.
                    if (word_xfer) begin
                        data_in[KEY_W-1-int'(cnt)*WORD_W -: WORD_W] <= in_data;
                        cnt <= cnt + 1'b1;
                        if (cnt == last_idx) begin
                            state <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    if (issue_xfer) begin
                        if (op_q == OP_KEY) begin
                            key_loaded <= 1'b1;
                        end
                        cnt   <= '0;
                        state <= S_HDR;
                    end
                end
                default: state <= S_HDR;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_cmd_packer.sv
// Scoreboard bench for aes_cmd_packer: expected commands are queued as packets are sent.
module tb_aes_cmd_packer;

    typedef struct packed {
        logic [6:0]   op;
        logic [255:0] data;
    } cmd_t;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [31:0]  in_data;
    logic         core_valid;
    logic         core_ready;
    logic [6:0]   opcode;
    logic [255:0] data_in;
    logic         err;
    logic         key_loaded;
    logic         busy;

    int   total = 0;
    int   bad = 0;
    int   cycle = 0;
    int   err_seen = 0;
    int   err_exp = 0;
    bit   model_key = 0;
    cmd_t sb[$];
    int   issue_edges[$];
    logic [31:0] pw[8];

    aes_cmd_packer dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .core_valid(core_valid), .core_ready(core_ready),
        .opcode(opcode), .data_in(data_in),
        .err(err), .key_loaded(key_loaded), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic checkOutput(input string tag, input logic [255:0] got, input logic [255:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Monitor: a handshake seen at the negedge completes on the following posedge.
    always @(negedge clk) begin
        if (!rst && core_valid && core_ready) begin
            if (sb.size() == 0) begin
                checkOutput("unexpected_issue", 1, 0);
            end else begin
                cmd_t e;
                e = sb.pop_front();
                checkOutput("sb_opcode", opcode, e.op);
                checkOutput("sb_data_in", data_in, e.data);
            end
            issue_edges.push_back(cycle + 1);
        end
        if (!rst && err) err_seen++;
    end

    task automatic applyStimulus(input logic [31:0] w);
        int n = 0;
        in_valid = 1'b1;
        in_data  = w;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) checkOutput("in_ready_timeout", 0, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic sendHeader(input logic [31:0] hdr);
        bit ok;
        ok = (hdr[6:0] == 7'd0) || ((hdr[6:0] == 7'd1 || hdr[6:0] == 7'd2) && model_key);
        applyStimulus(hdr);
        checkOutput("hdr_err", err, !ok);
        checkOutput("hdr_busy", busy, ok);
        if (!ok) err_exp++;
    endtask

    task automatic sendPacket(input logic [31:0] hdr, input int n);
        cmd_t c;
        sendHeader(hdr);
        c.op   = hdr[6:0];
        c.data = '0;
        for (int k = 0; k < n; k++) begin
            c.data[255-32*k -: 32] = pw[k];
            applyStimulus(pw[k]);
        end
        sb.push_back(c);
        if (hdr[6:0] == 7'd0) model_key = 1'b1;
    endtask

    task automatic nextEdge();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int h;
        rst        = 1'b1;
        in_valid   = 1'b0;
        in_data    = '0;
        core_ready = 1'b1;
        @(negedge clk);
        checkOutput("rst_in_ready", in_ready, 0);
        nextEdge();
        nextEdge();
        checkOutput("rst_core_valid", core_valid, 0);
        checkOutput("rst_opcode", opcode, 0);
        checkOutput("rst_data_in", data_in, 0);
        checkOutput("rst_key_loaded", key_loaded, 0);
        checkOutput("rst_busy", busy, 0);
        rst = 1'b0;
        #1;

        $display("[TB] encrypt before key");
        sendHeader(32'h1);
        checkOutput("nokey_core_valid", core_valid, 0);
        checkOutput("nokey_in_ready", in_ready, 1);
        nextEdge();
        checkOutput("nokey_err_drop", err, 0);

        $display("[TB] key load");
        for (int k = 0; k < 8; k++) pw[k] = 32'h00010203 + 32'h04040404 * k;
        sendPacket(32'h0, 8);
        checkOutput("key_latency", core_valid, 1);
        checkOutput("key_data_const", data_in,
                    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f);
        nextEdge();
        checkOutput("key_loaded", key_loaded, 1);
        checkOutput("key_done_valid", core_valid, 0);

        $display("[TB] encrypt with backpressure");
        core_ready = 1'b0;
        pw[0] = 32'h00112233; pw[1] = 32'h44556677; pw[2] = 32'h8899aabb; pw[3] = 32'hccddeeff;
        sendPacket(32'h1, 4);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("bp_core_valid", core_valid, 1);
            checkOutput("bp_in_ready", in_ready, 0);
            checkOutput("bp_opcode", opcode, 1);
            checkOutput("bp_data_in", data_in, {128'h00112233445566778899aabbccddeeff, 128'h0});
        end
        nextEdge();
        core_ready = 1'b1;
        nextEdge();
        checkOutput("bp_released", core_valid, 0);
        checkOutput("bp_sb_empty", sb.size(), 0);

        $display("[TB] bad opcodes parsed as headers");
        sendHeader(32'h00000005);
        sendHeader(32'h00000083);
        sendHeader(32'hffffff7f);
        pw[0] = 32'h11111111; pw[1] = 32'h22222222; pw[2] = 32'h33333333; pw[3] = 32'h44444444;
        sendPacket(32'haaaaaa82, 4);
        nextEdge();
        checkOutput("bad_sb_empty", sb.size(), 0);

        $display("[TB] reset mid-packet");
        sendHeader(32'h0);
        for (int k = 0; k < 3; k++) applyStimulus(32'hdead0000 + k);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("mid_rst_in_ready", in_ready, 0);
        checkOutput("mid_rst_core_valid", core_valid, 0);
        nextEdge();
        rst = 1'b0;
        model_key = 1'b0;
        checkOutput("mid_rst_opcode", opcode, 0);
        checkOutput("mid_rst_data_in", data_in, 0);
        checkOutput("mid_rst_key_loaded", key_loaded, 0);
        checkOutput("mid_rst_busy", busy, 0);
        checkOutput("mid_rst_err", err, 0);
        for (int k = 0; k < 8; k++) pw[k] = 32'hc0de0000 + 32'h00010001 * k;
        sendPacket(32'h0, 8);
        nextEdge();
        checkOutput("fresh_key_loaded", key_loaded, 1);

        $display("[TB] back-to-back stream");
        issue_edges.delete();
        for (int k = 0; k < 8; k++) pw[k] = 32'h50000000 + k;
        sendHeader(32'h0);
        h = cycle;
        for (int k = 0; k < 8; k++) applyStimulus(pw[k]);
        sb.push_back('{op: 7'd0, data: {pw[0], pw[1], pw[2], pw[3], pw[4], pw[5], pw[6], pw[7]}});
        for (int k = 0; k < 4; k++) pw[k] = 32'h60000000 + k;
        sendPacket(32'h1, 4);
        for (int k = 0; k < 4; k++) pw[k] = 32'h70000000 + k;
        sendPacket(32'h2, 4);
        for (int i = 0; i < 20 && issue_edges.size() < 3; i++) nextEdge();
        checkOutput("stream_issues", issue_edges.size(), 3);
        if (issue_edges.size() == 3) begin
            checkOutput("stream_key_period", issue_edges[0] - h + 1, 10);
            checkOutput("stream_enc_spacing", issue_edges[1] - issue_edges[0], 6);
            checkOutput("stream_dec_spacing", issue_edges[2] - issue_edges[1], 6);
        end

        nextEdge();
        checkOutput("final_sb_empty", sb.size(), 0);
        checkOutput("err_pulse_count", err_seen, err_exp);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
